// File: rtl/seg_pkg.sv
// Shared constants and the digit-to-segment decode for the single-digit counter.
// Segment vectors are ordered {A,B,C,D,E,F,G} and are active-low (0 = lit).
package seg_pkg;

    localparam logic [3:0] COUNT_MAX = 4'd9;

    localparam logic [6:0] SEG_0     = 7'b0000001;
    localparam logic [6:0] SEG_1     = 7'b1001111;
    localparam logic [6:0] SEG_2     = 7'b0010010;
    localparam logic [6:0] SEG_3     = 7'b0000110;
    localparam logic [6:0] SEG_4     = 7'b1001100;
    localparam logic [6:0] SEG_5     = 7'b0100100;
    localparam logic [6:0] SEG_6     = 7'b0100000;
    localparam logic [6:0] SEG_7     = 7'b0001111;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0000100;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    // Values 10-15 should never be held, but if they are the digit goes dark.
    function automatic logic [6:0] seg_decode(input logic [3:0] count);
        logic [6:0] seg;
        case (count)
            4'd0:    seg = SEG_0;
            4'd1:    seg = SEG_1;
            4'd2:    seg = SEG_2;
            4'd3:    seg = SEG_3;
            4'd4:    seg = SEG_4;
            4'd5:    seg = SEG_5;
            4'd6:    seg = SEG_6;
            4'd7:    seg = SEG_7;
            4'd8:    seg = SEG_8;
            4'd9:    seg = SEG_9;
            default: seg = SEG_BLANK;
        endcase
        return seg;
    endfunction

endpackage

// File: rtl/tick_divider.sv
// Programmable divider: raises tick for one cycle out of every DIV_COUNT cycles.
// Either the block reset or the divider-only reset restarts the period from zero.
module tick_divider #(
    parameter int DIV_COUNT = 50_000_000
) (
    input  logic Clk,
    input  logic Rst,
    input  logic DivRst,
    output logic tick
);

    localparam int          W    = $clog2(DIV_COUNT);
    localparam logic [W-1:0] LAST = W'(DIV_COUNT - 1);

    logic [W-1:0] div_cnt;

    always_ff @(posedge Clk) begin
        if (!Rst || !DivRst) begin
            div_cnt <= '0;
        end else if (div_cnt == LAST) begin
            div_cnt <= '0;
        end else begin
            div_cnt <= div_cnt + W'(1);
        end
    end

    assign tick = (div_cnt == LAST);

endmodule

// File: rtl/top.sv
// Single-digit up/down decimal counter driving one common-anode seven-segment digit.
// The count steps once per divider tick when enabled and wraps within 0-9.
module top
    import seg_pkg::*;
#(
    parameter int DIV_COUNT = 50_000_000
) (
    input  logic Clk,
    input  logic Rst,
    input  logic DivRst,
    input  logic En,
    input  logic U,
    output logic A,
    output logic B,
    output logic C,
    output logic D,
    output logic E,
    output logic F,
    output logic G,
    output logic SegSel
);

    logic       tick;
    logic [3:0] count;
    logic [3:0] next_count;

    tick_divider #(
        .DIV_COUNT(DIV_COUNT)
    ) u_div (
        .Clk    (Clk),
        .Rst    (Rst),
        .DivRst (DivRst),
        .tick   (tick)
    );

    // The >= guard also pulls an out-of-range value back to 0 when counting up.
    always_comb begin
        next_count = count;
        if (U) begin
            next_count = (count >= COUNT_MAX) ? 4'd0 : count + 4'd1;
        end else begin
            next_count = (count == 4'd0) ? COUNT_MAX : count - 4'd1;
        end
    end

    always_ff @(posedge Clk) begin
        if (!Rst) begin
            count <= 4'd0;
        end else if (tick && En) begin
            count <= next_count;
        end
    end

    assign {A, B, C, D, E, F, G} = seg_decode(count);
    assign SegSel = 1'b0;

endmodule

// File: tb/tb_top.sv
// Directed bench for the counter/display block with a divide-by-4 tick.
// Expected segment patterns come from the bench's own table and digit model.
module tb_top;
    import seg_pkg::*;

    logic Clk = 1'b0;
    logic Rst, DivRst, En, U;
    logic A, B, C, D, E, F, G, SegSel;

    int n_checks = 0;
    int n_fails  = 0;
    int digit    = 0;

    localparam logic [6:0] EXP_SEG [10] = '{
        7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110, 7'b1001100,
        7'b0100100, 7'b0100000, 7'b0001111, 7'b0000000, 7'b0000100
    };

    top #(
        .DIV_COUNT(4)
    ) dut (
        .Clk    (Clk),
        .Rst    (Rst),
        .DivRst (DivRst),
        .En     (En),
        .U      (U),
        .A      (A),
        .B      (B),
        .C      (C),
        .D      (D),
        .E      (E),
        .F      (F),
        .G      (G),
        .SegSel (SegSel)
    );

    always #5 Clk = ~Clk;

    // Inputs change and outputs are sampled 1 time unit after each rising edge.
    task automatic applyStimulus(input logic rst, input logic div_rst,
                                 input logic en, input logic u, input int cycles);
        Rst    = rst;
        DivRst = div_rst;
        En     = en;
        U      = u;
        for (int i = 0; i < cycles; i++) begin
            @(posedge Clk);
            #1;
        end
    endtask

    task automatic checkOutput(input string tag, input logic [7:0] observed,
                               input logic [7:0] expected);
        n_checks++;
        if (observed !== expected) begin
            n_fails++;
            $display("[TB] FAIL %s: got %b, expected %b", tag, observed, expected);
        end
    endtask

    function automatic logic [7:0] display_of(input int d);
        return {EXP_SEG[d], 1'b0};
    endfunction

    function automatic logic [7:0] observed_display();
        return {A, B, C, D, E, F, G, SegSel};
    endfunction

    // Run one full tick period: no change for three cycles, then the step.
    task automatic stepPeriod(input string tag, input logic u);
        applyStimulus(1'b1, 1'b1, 1'b1, u, 3);
        checkOutput({tag, "_hold"}, observed_display(), display_of(digit));
        digit = u ? (digit + 1) % 10 : (digit + 9) % 10;
        applyStimulus(1'b1, 1'b1, 1'b1, u, 1);
        checkOutput({tag, "_step"}, observed_display(), display_of(digit));
    endtask

    initial begin
        $display("[TB] Starting counter/display test");

        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 10);
        checkOutput("reset_seg", observed_display(), 8'b0000001_0);
        checkOutput("reset_tick", {7'd0, dut.tick}, 8'd0);
        checkOutput("blank_decode", {1'b0, seg_decode(4'd12)}, 8'b0_1111111);

        digit = 0;
        for (int i = 0; i < 12; i++) stepPeriod("count_up", 1'b1);
        checkOutput("up_ends_on_2", observed_display(), 8'b0010010_0);

        for (int i = 0; i < 4; i++) stepPeriod("count_down", 1'b0);
        checkOutput("down_wrap_8", observed_display(), 8'b0000000_0);

        applyStimulus(1'b1, 1'b1, 1'b0, 1'b1, 16);
        checkOutput("enable_off", observed_display(), display_of(digit));
        stepPeriod("reenable", 1'b1);

        applyStimulus(1'b1, 1'b0, 1'b1, 1'b1, 12);
        checkOutput("div_hold", observed_display(), display_of(digit));
        stepPeriod("div_release", 1'b1);

        for (int i = 0; i < 7; i++) stepPeriod("to_seven", 1'b1);
        checkOutput("at_seven", observed_display(), 8'b0001111_0);

        applyStimulus(1'b0, 1'b1, 1'b1, 1'b1, 1);
        digit = 0;
        checkOutput("mid_reset", observed_display(), display_of(0));
        stepPeriod("after_reset", 1'b1);

        // A divider pulse two cycles into a period restarts a full period.
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b1, 2);
        applyStimulus(1'b1, 1'b0, 1'b1, 1'b1, 1);
        checkOutput("div_pulse", observed_display(), display_of(digit));
        stepPeriod("after_div_pulse", 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
